// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-select codes, shift sub-codes and the
// sequencer state encoding.
package alu_pkg;

   localparam logic [1:0] ARITH = 2'b00;
   localparam logic [1:0] LOGIC = 2'b01;
   localparam logic [1:0] CMP   = 2'b10;
   localparam logic [1:0] SHIFT = 2'b11;

   localparam logic [1:0] SH_A_SHR = 2'b00;
   localparam logic [1:0] SH_A_SHL = 2'b01;
   localparam logic [1:0] SH_B_SHR = 2'b10;
   localparam logic [1:0] SH_B_SHL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } seq_state_t;

endpackage

// File: rtl/alu_unit_select.sv
// Decodes the unit field into a one-hot enable and muxes back the
// selected unit's flag and result.
module alu_unit_select
   import alu_pkg::*;
#(
   parameter int unsigned width = 16
) (
   input  logic [1:0]       unit,
   input  logic             issue,
   input  logic [3:0]       flags,
   input  logic [width-1:0] arith_out,
   input  logic [width-1:0] logic_out,
   input  logic [width-1:0] cmp_out,
   input  logic [width-1:0] shift_out,
   output logic [3:0]       enable,
   output logic             sel_flag,
   output logic [width-1:0] sel_out
);

   always_comb begin
      enable       = '0;
      sel_flag     = 1'b0;
      sel_out      = '0;
      enable[unit] = issue;
      case (unit)
         ARITH: begin sel_flag = flags[0]; sel_out = arith_out; end
         LOGIC: begin sel_flag = flags[1]; sel_out = logic_out; end
         CMP:   begin sel_flag = flags[2]; sel_out = cmp_out;   end
         SHIFT: begin sel_flag = flags[3]; sel_out = shift_out; end
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer: accepts one ALU op, enables the selected unit for
// one cycle, waits (bounded) for its flag and returns the result.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned width   = 16,
   parameter int unsigned TIMEOUT = 4
) (
   input  logic             clock,
   input  logic             rest,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_fun,
   input  logic [width-1:0] cmd_a,
   input  logic [width-1:0] cmd_b,
   output logic [width-1:0] alu_a,
   output logic [width-1:0] alu_b,
   output logic [3:0]       alu_fun,
   output logic             arith_enable,
   output logic             logic_enable,
   output logic             cmp_enable,
   output logic             shift_enable,
   input  logic             arith_flag,
   input  logic             logic_flag,
   input  logic             cmp_flag,
   input  logic             shift_flag,
   input  logic [width-1:0] arith_out,
   input  logic [width-1:0] logic_out,
   input  logic [width-1:0] cmp_out,
   input  logic [width-1:0] shift_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [width-1:0] res_data,
   output logic [3:0]       res_fun,
   output logic             res_timeout,
   output logic             busy
);

   localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(TIMEOUT - 1);

   seq_state_t       state;
   logic [CW-1:0]    wait_cnt;
   logic [3:0]       enable;
   logic             sel_flag;
   logic [width-1:0] sel_out;

   // Enables decode straight from the ISSUE state and the latched code,
   // so they are high for exactly the single ISSUE cycle.
   alu_unit_select #(.width(width)) u_select (
      .unit      (alu_fun[3:2]),
      .issue     (state == ISSUE),
      .flags     ({shift_flag, cmp_flag, logic_flag, arith_flag}),
      .arith_out (arith_out),
      .logic_out (logic_out),
      .cmp_out   (cmp_out),
      .shift_out (shift_out),
      .enable    (enable),
      .sel_flag  (sel_flag),
      .sel_out   (sel_out)
   );

   assign {shift_enable, cmp_enable, logic_enable, arith_enable} = enable;

   always_ff @(posedge clock) begin
      if (!rest) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_fun     <= '0;
         res_data    <= '0;
         res_fun     <= '0;
         res_timeout <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         cmd_ready   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_a     <= cmd_a;
                  alu_b     <= cmd_b;
                  alu_fun   <= cmd_fun;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // A flag on the terminal-count cycle still wins over timeout.
               if (sel_flag) begin
                  res_data    <= sel_out;
                  res_timeout <= 1'b0;
                  res_fun     <= alu_fun;
                  res_valid   <= 1'b1;
                  state       <= RESP;
               end else if (wait_cnt == LAST_CNT) begin
                  res_data    <= '0;
                  res_timeout <= 1'b1;
                  res_fun     <= alu_fun;
                  res_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with registered unit models and a
// transaction-level latency/result reference.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int W  = 16;
   localparam int TO = 4;

   typedef struct {
      logic [3:0]   fun;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      int           hold;
      bit           force_stray;
   } op_t;

   logic         clock = 1'b0;
   logic         rest;
   logic         cmd_valid, cmd_ready;
   logic [3:0]   cmd_fun;
   logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b;
   logic [3:0]   alu_fun;
   logic         arith_enable, logic_enable, cmp_enable, shift_enable;
   logic [3:0]   uflag = '0;
   logic [3:0]   stray;
   logic [W-1:0] uout [4];
   logic         res_valid, res_ready, res_timeout, busy;
   logic [W-1:0] res_data;
   logic [3:0]   res_fun;
   logic [3:0]   en;

   int           checks = 0;
   int           errors = 0;
   int           lat [4] = '{0, 0, 0, 0};
   int           cd  [4] = '{0, 0, 0, 0};
   logic [W-1:0] held [4];

   always #5 clock = ~clock;

   assign en = {shift_enable, cmp_enable, logic_enable, arith_enable};

   alu_op_sequencer #(.width(W), .TIMEOUT(TO)) dut (
      .clock(clock), .rest(rest),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
      .arith_enable(arith_enable), .logic_enable(logic_enable),
      .cmp_enable(cmp_enable), .shift_enable(shift_enable),
      .arith_flag(uflag[0] | stray[0]), .logic_flag(uflag[1] | stray[1]),
      .cmp_flag(uflag[2] | stray[2]), .shift_flag(uflag[3] | stray[3]),
      .arith_out(uout[0]), .logic_out(uout[1]), .cmp_out(uout[2]), .shift_out(uout[3]),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_fun(res_fun), .res_timeout(res_timeout), .busy(busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] unit_result(input logic [3:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      case (f[3:2])
         ARITH: case (f[1:0])
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a + 1'b1;
            default: r = a - 1'b1;
         endcase
         LOGIC: case (f[1:0])
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: r = a ^ b;
            default: r = ~(a & b);
         endcase
         CMP: case (f[1:0])
            2'b00: r = W'(a == b);
            2'b01: r = W'(a < b);
            2'b10: r = W'(a > b);
            default: r = W'(a != b);
         endcase
         default: case (f[1:0])
            SH_A_SHR: r = a >> 1;
            SH_A_SHL: r = a << 1;
            SH_B_SHR: r = b >> 1;
            default:  r = b << 1;
         endcase
      endcase
      return r;
   endfunction

   // Registered unit bank: flag pulses lat[u] cycles after the enable cycle
   // (lat 0 = never); outputs are noise except on the flag cycle.
   always @(posedge clock) begin
      for (int u = 0; u < 4; u++) begin
         if (en[u]) begin
            cd[u]   = lat[u];
            held[u] = unit_result(alu_fun, alu_a, alu_b);
         end
         if (cd[u] > 0) begin
            cd[u]   = cd[u] - 1;
            uflag[u] <= (cd[u] == 0);
            uout[u]  <= (cd[u] == 0) ? held[u] : W'($urandom);
         end else begin
            uflag[u] <= 1'b0;
            uout[u]  <= W'($urandom);
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check_val({tag, "_alu_a"}, alu_a, 0);
      check_val({tag, "_alu_b"}, alu_b, 0);
      check_val({tag, "_alu_fun"}, alu_fun, 0);
      check_val({tag, "_res_data"}, res_data, 0);
      check_val({tag, "_res_fun"}, res_fun, 0);
      check_val({tag, "_res_timeout"}, res_timeout, 0);
      check_val({tag, "_enables"}, en, 0);
      check_val({tag, "_res_valid"}, res_valid, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   // Entered at a negedge with the DUT idle; leaves at the negedge of the
   // following idle cycle with the next command (if any) already offered.
   task automatic run_op(input op_t o, input bit has_next, input op_t nx);
      logic [3:0]   onehot;
      logic [W-1:0] exp_d;
      bit           exp_to;
      int           d, n;
      onehot = 4'b0001 << o.fun[3:2];
      exp_to = !(o.lat >= 1 && o.lat <= TO);
      d      = exp_to ? TO : o.lat;
      exp_d  = exp_to ? '0 : unit_result(o.fun, o.a, o.b);
      lat[o.fun[3:2]] = o.lat;
      cmd_fun = o.fun; cmd_a = o.a; cmd_b = o.b; cmd_valid = 1'b1;
      res_ready = (o.hold == 0);
      stray = '0;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clock); n++; end
      check_val("cmd_ready_idle", cmd_ready, 1);
      check_val("enables_idle", en, 0);
      @(negedge clock);
      if (has_next) begin
         cmd_fun = nx.fun; cmd_a = nx.a; cmd_b = nx.b; cmd_valid = 1'b1;
      end else cmd_valid = 1'b0;
      check_val("enable_issue", en, onehot);
      check_val("alu_a", alu_a, o.a);
      check_val("alu_b", alu_b, o.b);
      check_val("alu_fun", alu_fun, o.fun);
      check_val("busy_issue", busy, 1);
      check_val("cmd_ready_issue", cmd_ready, 0);
      for (int k = 1; k <= d; k++) begin
         @(negedge clock);
         check_val("res_valid_wait", res_valid, 0);
         check_val("enables_wait", en, 0);
         check_val("cmd_ready_wait", cmd_ready, 0);
         stray = (o.force_stray ? 4'hF : 4'($urandom)) & ~onehot;
      end
      @(negedge clock);
      stray = '0;
      check_val("res_valid", res_valid, 1);
      check_val("res_data", res_data, exp_d);
      check_val("res_fun", res_fun, o.fun);
      check_val("res_timeout", res_timeout, exp_to);
      check_val("busy_resp", busy, 1);
      for (int h = 1; h < o.hold; h++) begin
         @(negedge clock);
         check_val("hold_res_valid", res_valid, 1);
         check_val("hold_res_data", res_data, exp_d);
         check_val("hold_res_fun", res_fun, o.fun);
         check_val("hold_res_timeout", res_timeout, exp_to);
         check_val("hold_cmd_ready", cmd_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clock);
      check_val("res_valid_done", res_valid, 0);
      check_val("cmd_ready_done", cmd_ready, 1);
      check_val("busy_done", busy, 0);
   endtask

   task automatic run_queue(input op_t q[$]);
      for (int i = 0; i < q.size(); i++)
         run_op(q[i], (i + 1) < q.size(), q[(i + 1) < q.size() ? i + 1 : i]);
   endtask

   function automatic op_t mk(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int l, input int h, input bit s);
      op_t o;
      o.fun = f; o.a = a; o.b = b; o.lat = l; o.hold = h; o.force_stray = s;
      return o;
   endfunction

   initial begin
      op_t q[$];
      rest = 1'b0; cmd_valid = 1'b0; cmd_fun = '0; cmd_a = '0; cmd_b = '0;
      res_ready = 1'b0; stray = '0;
      repeat (2) @(negedge clock);
      check_reset_values("reset");
      rest = 1'b1;
      @(negedge clock);
      check_reset_values("post_reset");

      q = {};
      q.push_back(mk(4'b1100, 16'h8000, 16'h1234, 1, 0, 1'b0));
      q.push_back(mk(4'b1111, 16'h5555, 16'h4001, 1, 0, 1'b0));
      q.push_back(mk(4'b0110, 16'hF0F0, 16'h0FF0, 1, 5, 1'b0));
      q.push_back(mk(4'b1001, 16'h0003, 16'h0007, 1, 0, 1'b0));
      q.push_back(mk(4'b0000, 16'h1111, 16'h2222, 0, 0, 1'b1));
      q.push_back(mk(4'b0101, 16'hA000, 16'h000A, TO, 0, 1'b1));
      q.push_back(mk(4'b0001, 16'h0100, 16'h0001, TO + 1, 2, 1'b0));
      q.push_back(mk(4'b0110, 16'h1234, 16'hFFFF, 1, 0, 1'b0));
      q.push_back(mk(4'b1011, 16'h0042, 16'h0043, 1, 0, 1'b0));
      q.push_back(mk(4'b1101, 16'hC001, 16'h0000, 1, 0, 1'b0));
      run_queue(q);

      // Reset while the flag is about to arrive: op must vanish.
      lat[1] = 1;
      cmd_fun = 4'b0100; cmd_a = 16'hBEEF; cmd_b = 16'h00FF; cmd_valid = 1'b1; res_ready = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      @(negedge clock);
      rest = 1'b0;
      @(negedge clock);
      check_reset_values("midop_reset");
      rest = 1'b1;
      repeat (6) begin
         @(negedge clock);
         check_val("dropped_no_resp", res_valid, 0);
      end
      q = {};
      q.push_back(mk(4'b0010, 16'h7FFF, 16'h0001, 2, 1, 1'b0));
      run_queue(q);

      q = {};
      for (int i = 0; i < 40; i++)
         q.push_back(mk(4'($urandom), W'($urandom), W'($urandom),
                        int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)), 1'b0));
      run_queue(q);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side controller that drives the ALU execution units (arithmetic, logic, compare, shift) through their enable/flag interface. It accepts one operation per valid/ready handshake and decodes ALU_FUN[3:2] into a one-hot unit enable. It then waits for that unit's registered flag and returns the result through a valid/ready response port. It sits between the datapath control and the ALU unit bank, and is the initiator for units such as the shift unit.

Parameters:
width, 16, operand/result width
TIMEOUT, 4, maximum WAIT cycles for the selected unit's flag before aborting (>=1)

Ports:
clock  in  1  system clock, rising edge
rest  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_fun  in  4  ALU_FUN code; [3:2] selects unit, [1:0] passed to unit
cmd_a  in  width  operand A
cmd_b  in  width  operand B
alu_a  out  width  operand A to unit bank
alu_b  out  width  operand B to unit bank
alu_fun  out  4  function code to unit bank
arith_enable, logic_enable, cmp_enable, shift_enable  out  1 each  unit enables, at most one high
arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  registered unit-valid flags
arith_out, logic_out, cmp_out, shift_out  in  width each  registered unit results
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  width  captured result
res_fun  out  4  function code of this result
res_timeout  out  1  result aborted by timeout (res_data=0)
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Binary encoding.
- Reset (rest=0 at a rising edge) has priority over all other events:
  - state goes to IDLE; wait counter is cleared.
  - alu_a, alu_b, alu_fun, res_data, res_fun, res_timeout are cleared to 0.
  - All four enables, res_valid and busy are 0; cmd_ready is 1 after reset.
  - Reset mid-operation drops the in-flight operation; no response is produced.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_a/cmd_b/cmd_fun into alu_a/alu_b/alu_fun and go to ISSUE.
- ISSUE, exactly one cycle:
  - Assert the enable selected by alu_fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - All enables are 0; the counter increments each cycle.
  - If the flag of the selected unit is 1: capture that unit's out into res_data, set res_timeout=0, go to RESP.
  - Else, if the counter reaches TIMEOUT-1 in this cycle: set res_data=0, res_timeout=1, go to RESP.
  - Flags from non-selected units are ignored in every state.
  - If the flag and the timeout terminal count occur together, the flag wins.
- RESP:
  - res_valid=1; res_data, res_fun (=alu_fun) and res_timeout are held stable.
  - On res_ready go to IDLE.
  - res_valid must not drop without res_ready.
- cmd_ready=0 outside IDLE. A command offered during ISSUE/WAIT/RESP waits; it is not dropped.
- Latency:
  - Handshake in cycle N; enable high in cycle N+1.
  - Flag sampled in cycle N+2; res_valid high in cycle N+3 (registered unit with one-cycle latency).
- Peak throughput is one operation per 4 cycles with res_ready tied high.
- alu_a, alu_b and alu_fun hold their latched values until the next accepted command.
- Counter width: clog2(TIMEOUT+1).

Decomposition:
- Shared package alu_pkg contains:
  - unit-select constants: ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11;
  - shift sub-codes 00 A>>1, 01 A<<1, 10 B>>1, 11 B<<1;
  - the sequencer state encoding.
- One sub-module, alu_unit_select:
  - combinational decode of fun[3:2] plus an issue strobe into the one-hot enable vector;
  - mux of the selected flag and result.

Test Plan:
- Shift A>>1: cmd_fun=4'b1100, cmd_a=16'h8000, res_ready=1, unit model registered -> shift_enable high only in N+1; res_valid at N+3 with res_data=16'h4000, res_fun=4'b1100, res_timeout=0.
- Shift B<<1: cmd_fun=4'b1111, cmd_b=16'h4001 -> res_data=16'h8002; no other enable ever asserts.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid, res_data, res_fun stable; cmd_ready=0 throughout; a second cmd_valid is held off; it is accepted in the first IDLE cycle after res_ready.
- Timeout: cmd_fun=4'b0000, arith model never flags, TIMEOUT=4 -> 4 WAIT cycles, then res_valid with res_timeout=1, res_data=0; a stray shift_flag=1 pulse during WAIT is ignored.
- Reset mid-op: rest=0 during WAIT -> at the next edge state is IDLE, all outputs are at reset values, no res_valid ever appears for the dropped op; a new command then completes normally.
- Back-to-back: 3 commands (logic, cmp, shift) with cmd_valid held high and res_ready=1 -> 3 results in order, accepted every 4 cycles, each res_fun matching its command.
